// File: rtl/smi_phy_monitor.sv
// Multi-PHY MDIO poller: walks NUM_PHY PHYs, reads status and vendor speed registers, publishes link/speed.
// Optional first-sweep autoneg restart write is compiled in with `define SMI_MON_INIT_EN.
module smi_phy_monitor #(
  parameter int unsigned NUM_PHY       = 2,
  parameter int unsigned PHY_ADDR_BASE = 0,
  parameter logic [4:0]  STAT_REG      = 5'd1,
  parameter logic [4:0]  SPD_REG       = 5'd31,
  parameter int unsigned PWRUP_CYC     = 3_000_000,
  parameter int unsigned POLL_CYC      = 50_000_000,
  parameter int unsigned TMO_CYC       = 65_535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 smi_req,
  output logic                 smi_wr,
  output logic [4:0]           smi_phy_addr,
  output logic [4:0]           smi_reg_addr,
  output logic [15:0]          smi_wdata,
  input  logic [15:0]          smi_rdata,
  input  logic                 smi_done,
  output logic [NUM_PHY-1:0]   link,
  output logic [2*NUM_PHY-1:0] speed,
  output logic [NUM_PHY-1:0]   status_chg,
  output logic [NUM_PHY-1:0]   smi_err,
  output logic                 busy
);

  localparam int unsigned CH_W    = (NUM_PHY > 1) ? $clog2(NUM_PHY) : 1;
  localparam logic [1:0]  SPD_UNK = 2'b11;

  typedef enum logic [3:0] {
    S_PWRUP, S_INIT_REQ, S_INIT_WAIT, S_STAT_REQ, S_STAT_WAIT,
    S_SPD_REQ, S_SPD_WAIT, S_UPDATE, S_NEXT, S_POLL_WAIT
  } state_e;

  state_e                 state_q, state_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic                   pend_link_q, pend_link_d;
  logic [1:0]             pend_spd_q, pend_spd_d;
  logic [NUM_PHY-1:0]     link_q, link_d;
  logic [2*NUM_PHY-1:0]   speed_q, speed_d;
  logic [NUM_PHY-1:0]     chg_q, chg_d;
  logic [NUM_PHY-1:0]     err_q, err_d;
  logic                   req_q, req_d;
  logic [4:0]             phy_addr_q, phy_addr_d;
  logic [4:0]             reg_addr_q, reg_addr_d;
  logic                   busy_q, busy_d;
`ifdef SMI_MON_INIT_EN
  logic                   first_q, first_d;
  logic                   wr_q, wr_d;
  logic [15:0]            wdata_q, wdata_d;
`endif

  logic [4:0] ch_addr;
  logic       tmo_hit;
  logic       unused_rdata;

  assign ch_addr      = 5'(PHY_ADDR_BASE + 32'(ch_q));
  assign tmo_hit      = (cnt_q == 32'(TMO_CYC));
  assign unused_rdata = ^{smi_rdata[15:7], smi_rdata[3], smi_rdata[1:0]};

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ch_d        = ch_q;
    pend_link_d = pend_link_q;
    pend_spd_d  = pend_spd_q;
    link_d      = link_q;
    speed_d     = speed_q;
    chg_d       = '0;
    err_d       = err_q;
    req_d       = 1'b0;
    phy_addr_d  = phy_addr_q;
    reg_addr_d  = reg_addr_q;
`ifdef SMI_MON_INIT_EN
    first_d     = first_q;
    wr_d        = wr_q;
    wdata_d     = wdata_q;
`endif

    case (state_q)
      S_PWRUP: begin
        if (cnt_q == 32'(PWRUP_CYC - 1)) begin
          cnt_d = '0;
`ifdef SMI_MON_INIT_EN
          state_d = S_INIT_REQ;
`else
          state_d = S_STAT_REQ;
`endif
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
`ifdef SMI_MON_INIT_EN
      S_INIT_REQ: begin
        req_d      = 1'b1;
        phy_addr_d = ch_addr;
        reg_addr_d = 5'd0;
        wr_d       = 1'b1;
        wdata_d    = 16'h1340;
        cnt_d      = '0;
        state_d    = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        if (smi_done) begin
          state_d = S_STAT_REQ;
        end else if (tmo_hit) begin
          err_d[ch_q] = 1'b1;
          pend_link_d = 1'b0;
          pend_spd_d  = SPD_UNK;
          state_d     = S_UPDATE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
`endif
      S_STAT_REQ: begin
        req_d      = 1'b1;
        phy_addr_d = ch_addr;
        reg_addr_d = STAT_REG;
`ifdef SMI_MON_INIT_EN
        wr_d       = 1'b0;
        wdata_d    = 16'h0;
`endif
        cnt_d      = '0;
        state_d    = S_STAT_WAIT;
      end
      S_STAT_WAIT: begin
        if (smi_done) begin
          if (smi_rdata[2]) begin
            state_d = S_SPD_REQ;
          end else begin
            pend_link_d = 1'b0;
            pend_spd_d  = SPD_UNK;
            state_d     = S_UPDATE;
          end
        end else if (tmo_hit) begin
          err_d[ch_q] = 1'b1;
          pend_link_d = 1'b0;
          pend_spd_d  = SPD_UNK;
          state_d     = S_UPDATE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_SPD_REQ: begin
        req_d      = 1'b1;
        phy_addr_d = ch_addr;
        reg_addr_d = SPD_REG;
        cnt_d      = '0;
        state_d    = S_SPD_WAIT;
      end
      S_SPD_WAIT: begin
        if (smi_done) begin
          state_d = S_UPDATE;
          // Exactly one-hot codes are valid; anything else reads as link down.
          case (smi_rdata[6:4])
            3'b100:  begin pend_link_d = 1'b1; pend_spd_d = 2'b10;   end
            3'b010:  begin pend_link_d = 1'b1; pend_spd_d = 2'b01;   end
            3'b001:  begin pend_link_d = 1'b1; pend_spd_d = 2'b00;   end
            default: begin pend_link_d = 1'b0; pend_spd_d = SPD_UNK; end
          endcase
        end else if (tmo_hit) begin
          err_d[ch_q] = 1'b1;
          pend_link_d = 1'b0;
          pend_spd_d  = SPD_UNK;
          state_d     = S_UPDATE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_UPDATE: begin
        link_d[ch_q]                = pend_link_q;
        speed_d[{ch_q, 1'b0} +: 2]  = pend_spd_q;
        chg_d[ch_q] = (link_q[ch_q] != pend_link_q) ||
                      (speed_q[{ch_q, 1'b0} +: 2] != pend_spd_q);
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (ch_q == CH_W'(NUM_PHY - 1)) begin
          ch_d    = '0;
          cnt_d   = '0;
          state_d = S_POLL_WAIT;
`ifdef SMI_MON_INIT_EN
          first_d = 1'b0;
`endif
        end else begin
          ch_d    = ch_q + CH_W'(1);
`ifdef SMI_MON_INIT_EN
          state_d = first_q ? S_INIT_REQ : S_STAT_REQ;
`else
          state_d = S_STAT_REQ;
`endif
        end
      end
      S_POLL_WAIT: begin
        if (cnt_q == 32'(POLL_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_STAT_REQ;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = S_PWRUP;
    endcase

    busy_d = (state_d != S_PWRUP) && (state_d != S_POLL_WAIT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_PWRUP;
      cnt_q       <= '0;
      ch_q        <= '0;
      pend_link_q <= 1'b0;
      pend_spd_q  <= SPD_UNK;
      link_q      <= '0;
      speed_q     <= '1;
      chg_q       <= '0;
      err_q       <= '0;
      req_q       <= 1'b0;
      phy_addr_q  <= '0;
      reg_addr_q  <= '0;
      busy_q      <= 1'b0;
`ifdef SMI_MON_INIT_EN
      first_q     <= 1'b1;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ch_q        <= ch_d;
      pend_link_q <= pend_link_d;
      pend_spd_q  <= pend_spd_d;
      link_q      <= link_d;
      speed_q     <= speed_d;
      chg_q       <= chg_d;
      err_q       <= err_d;
      req_q       <= req_d;
      phy_addr_q  <= phy_addr_d;
      reg_addr_q  <= reg_addr_d;
      busy_q      <= busy_d;
`ifdef SMI_MON_INIT_EN
      first_q     <= first_d;
      wr_q        <= wr_d;
      wdata_q     <= wdata_d;
`endif
    end
  end

  assign smi_req      = req_q;
  assign smi_phy_addr = phy_addr_q;
  assign smi_reg_addr = reg_addr_q;
`ifdef SMI_MON_INIT_EN
  assign smi_wr       = wr_q;
  assign smi_wdata    = wdata_q;
`else
  assign smi_wr       = 1'b0;
  assign smi_wdata    = 16'h0;
`endif
  assign link         = link_q;
  assign speed        = speed_q;
  assign status_chg   = chg_q;
  assign smi_err      = err_q;
  assign busy         = busy_q;

endmodule
